// File: rtl/product_accumulator.sv
// Purpose : sums groups of unsigned 16-bit products into a wide accumulator.
// Latency : result registered; out_valid rises on the edge that accepts the closing beat.
// Backpr. : in_ready drops while a result waits in HOLD; pending input beats stall.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   acc_clr               synchronous abort of the current group or pending result
//   in_valid/in_ready     product beat handshake; in_p product, in_last group end
//   out_valid/out_ready   result handshake; out_sum, out_count, out_ovf
// Build option: PRODUCT_ACC_SAT_EN makes the accumulator saturate instead of wrap.
module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               acc_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_p,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W:0]     out_count,
  output logic               out_ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             accept;
  logic             close;
  logic [ACC_W:0]   sum_full;
  logic             carry;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W:0]   count_nxt;

  assign accept    = in_valid && in_ready;
  // Closing on cnt == all-ones means the group held 2^CNT_W products.
  assign close     = accept && (in_last || (cnt == {CNT_W{1'b1}}));
  assign sum_full  = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, in_p};
  assign carry     = sum_full[ACC_W];
  assign count_nxt = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

`ifdef PRODUCT_ACC_SAT_EN
  // Once saturated, every further nonzero product carries again, so acc pins at max.
  assign acc_nxt = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign acc_nxt = sum_full[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = !acc_clr;
        if (close) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (acc_clr || out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (acc_clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (close) begin
      out_sum   <= acc_nxt;
      out_count <= count_nxt;
      out_ovf   <= ovf | carry;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
      ovf <= ovf | carry;
    end
  end

endmodule
